c1_bus_arbiter: RTL and testbench

//  Shares the cache's CPU-side bus-1 port between two requesters (r0 = instr, r1 = data).

---
 rtl/c1_bus_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_c1_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c1_bus_arbiter.sv
// ============================================================================
//  c1_bus_arbiter
//  Round-robin arbiter that shares the cache bus-1 port between the
//  instruction (r0) and data (r1) front-ends, one transaction at a time.
//  Rev 1.0  - initial release
// ============================================================================
`default_nettype none

module c1_bus_arbiter #(
    parameter int TAG_SET_W = 10,
    parameter int OFFSET_W  = 4,
    parameter int DATA1_W   = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                          CLK,
    input  logic                          RESET,

    input  logic                          r0_req,
    input  logic [2:0]                    r0_cmd,
    input  logic [TAG_SET_W+OFFSET_W-1:0] r0_addr,
    input  logic [31:0]                   r0_wdata,
    output logic                          r0_gnt,
    output logic                          r0_done,
    output logic [31:0]                   r0_rdata,

    input  logic                          r1_req,
    input  logic [2:0]                    r1_cmd,
    input  logic [TAG_SET_W+OFFSET_W-1:0] r1_addr,
    input  logic [31:0]                   r1_wdata,
    output logic                          r1_gnt,
    output logic                          r1_done,
    output logic [31:0]                   r1_rdata,

    output logic [2:0]                    c1_out,
    output logic [TAG_SET_W-1:0]          a1_out,
    output logic [DATA1_W-1:0]            d1_out,
    output logic                          d1_oe,
    input  logic [2:0]                    c1_in,
    input  logic [DATA1_W-1:0]            d1_in,
    output logic                          timeout_err
);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_READ8    = 3'd1;
    localparam logic [2:0] OP_READ16   = 3'd2;
    localparam logic [2:0] OP_READ32   = 3'd3;
    localparam logic [2:0] OP_INV_LINE = 3'd4;
    localparam logic [2:0] OP_WRITE32  = 3'd7;
    localparam logic [2:0] OP_RESPONSE = 3'd7;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD1  = 3'd1,
        S_CMD2  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP2 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state;
    logic                last_served;   // also identifies the owner of the active transaction
    logic [2:0]          cmd_q;
    logic [OFFSET_W-1:0] off_q;
    logic [15:0]         whi_q;
    logic [15:0]         lo_q;
    logic [CNT_W-1:0]    cnt;

    logic                          elig0;
    logic                          elig1;
    logic                          pick1;
    logic [2:0]                    ch_cmd;
    logic [TAG_SET_W+OFFSET_W-1:0] ch_addr;
    logic [31:0]                   ch_wdata;
    logic                          ch_write;

    logic        finish;
    logic        fin_timeout;
    logic [31:0] fin_data;

    assign elig0    = r0_req && (r0_cmd != OP_NOP);
    assign elig1    = r1_req && (r1_cmd != OP_NOP);
    // r1 wins when it is the only one asking, or on a tie when r0 was served last
    assign pick1    = elig1 && (!elig0 || !last_served);
    assign ch_cmd   = pick1 ? r1_cmd   : r0_cmd;
    assign ch_addr  = pick1 ? r1_addr  : r0_addr;
    assign ch_wdata = pick1 ? r1_wdata : r0_wdata;
    assign ch_write = ch_cmd[2] && (ch_cmd != OP_INV_LINE);

    // Completion decode for WAIT / RESP2; READ32 needs a second response cycle.
    always_comb begin
        finish      = 1'b0;
        fin_timeout = 1'b0;
        fin_data    = 32'h0;
        if (state == S_WAIT) begin
            if (c1_in == OP_RESPONSE) begin
                case (cmd_q)
                    OP_READ8: begin
                        finish   = 1'b1;
                        fin_data = {24'h0, d1_in[7:0]};
                    end
                    OP_READ16: begin
                        finish   = 1'b1;
                        fin_data = {16'h0, d1_in[15:0]};
                    end
                    OP_READ32: begin
                        finish   = 1'b0;
                    end
                    default: begin
                        finish   = 1'b1;
                    end
                endcase
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                finish      = 1'b1;
                fin_timeout = 1'b1;
            end
        end else if (state == S_RESP2) begin
            finish   = 1'b1;
            fin_data = {d1_in[15:0], lo_q};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
            cmd_q       <= OP_NOP;
            off_q       <= '0;
            whi_q       <= 16'h0;
            lo_q        <= 16'h0;
            cnt         <= '0;
            r0_gnt      <= 1'b0;
            r1_gnt      <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            r0_rdata    <= 32'h0;
            r1_rdata    <= 32'h0;
            c1_out      <= OP_NOP;
            a1_out      <= '0;
            d1_out      <= '0;
            d1_oe       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Outputs are registered: each branch sets up the values for the next state.
            r0_gnt      <= 1'b0;
            r1_gnt      <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            r0_rdata    <= 32'h0;
            r1_rdata    <= 32'h0;
            c1_out      <= OP_NOP;
            a1_out      <= '0;
            d1_out      <= '0;
            d1_oe       <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (elig0 || elig1) begin
                        last_served <= pick1;
                        cmd_q       <= ch_cmd;
                        off_q       <= ch_addr[OFFSET_W-1:0];
                        whi_q       <= ch_wdata[31:16];
                        r0_gnt      <= !pick1;
                        r1_gnt      <= pick1;
                        c1_out      <= ch_cmd;
                        a1_out      <= ch_addr[TAG_SET_W+OFFSET_W-1:OFFSET_W];
                        if (ch_write) begin
                            d1_oe  <= 1'b1;
                            d1_out <= DATA1_W'(ch_wdata[15:0]);
                        end
                        state <= S_CMD1;
                    end
                end

                S_CMD1: begin
                    c1_out <= cmd_q;
                    a1_out <= TAG_SET_W'(off_q);
                    if (cmd_q == OP_WRITE32) begin
                        d1_oe  <= 1'b1;
                        d1_out <= DATA1_W'(whi_q);
                    end
                    state <= S_CMD2;
                end

                S_CMD2: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (finish) begin
                        r0_done     <= !last_served;
                        r1_done     <= last_served;
                        r0_rdata    <= last_served ? 32'h0 : fin_data;
                        r1_rdata    <= last_served ? fin_data : 32'h0;
                        timeout_err <= fin_timeout;
                        state       <= S_DONE;
                    end else if (c1_in == OP_RESPONSE) begin
                        lo_q  <= d1_in[15:0];
                        state <= S_RESP2;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RESP2: begin
                    r0_done  <= !last_served;
                    r1_done  <= last_served;
                    r0_rdata <= last_served ? 32'h0 : fin_data;
                    r1_rdata <= last_served ? fin_data : 32'h0;
                    state    <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_c1_bus_arbiter.sv
// ============================================================================
//  tb_c1_bus_arbiter
//  Randomised transaction-level bench for c1_bus_arbiter with a cache model.
//  Rev 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_c1_bus_arbiter;

    localparam int TS = 10;
    localparam int OW = 4;
    localparam int DW = 16;
    localparam int TO = 4;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_READ8   = 3'd1;
    localparam logic [2:0] OP_READ16  = 3'd2;
    localparam logic [2:0] OP_READ32  = 3'd3;
    localparam logic [2:0] OP_WRITE32 = 3'd7;

    logic              CLK;
    logic              RESET;
    logic              r0_req, r1_req;
    logic [2:0]        r0_cmd, r1_cmd;
    logic [TS+OW-1:0]  r0_addr, r1_addr;
    logic [31:0]       r0_wdata, r1_wdata;
    logic              r0_gnt, r1_gnt, r0_done, r1_done;
    logic [31:0]       r0_rdata, r1_rdata;
    logic [2:0]        c1_out;
    logic [TS-1:0]     a1_out;
    logic [DW-1:0]     d1_out;
    logic              d1_oe;
    logic [2:0]        c1_in;
    logic [DW-1:0]     d1_in;
    logic              timeout_err;

    c1_bus_arbiter #(
        .TAG_SET_W (TS),
        .OFFSET_W  (OW),
        .DATA1_W   (DW),
        .TIMEOUT   (TO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .r0_req      (r0_req),
        .r0_cmd      (r0_cmd),
        .r0_addr     (r0_addr),
        .r0_wdata    (r0_wdata),
        .r0_gnt      (r0_gnt),
        .r0_done     (r0_done),
        .r0_rdata    (r0_rdata),
        .r1_req      (r1_req),
        .r1_cmd      (r1_cmd),
        .r1_addr     (r1_addr),
        .r1_wdata    (r1_wdata),
        .r1_gnt      (r1_gnt),
        .r1_done     (r1_done),
        .r1_rdata    (r1_rdata),
        .c1_out      (c1_out),
        .a1_out      (a1_out),
        .d1_out      (d1_out),
        .d1_oe       (d1_oe),
        .c1_in       (c1_in),
        .d1_in       (d1_in),
        .timeout_err (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Pending request per requester, and the arbiter's tie-break memory (1: r1 served last).
    bit          pend  [2];
    logic [2:0]  pcmd  [2];
    logic [13:0] paddr [2];
    logic [31:0] pwd   [2];
    bit          last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_reqs();
        r0_req = pend[0]; r0_cmd = pcmd[0]; r0_addr = paddr[0]; r0_wdata = pwd[0];
        r1_req = pend[1]; r1_cmd = pcmd[1]; r1_addr = paddr[1]; r1_wdata = pwd[1];
    endtask

    task automatic post(input int n, input logic [2:0] cmd, input logic [13:0] addr, input logic [31:0] wd);
        pend[n] = 1'b1; pcmd[n] = cmd; paddr[n] = addr; pwd[n] = wd;
    endtask

    // Runs one transaction from an IDLE cycle; the cache answers after 'delay' WAIT cycles
    // (delay >= TO means it never answers). rst_mid aborts with RESET in the second WAIT cycle.
    task automatic run_txn(input int delay, input logic [15:0] dlo, input logic [15:0] dhi, input bit rst_mid);
        bit          e0, e1, wr, responded, timed;
        int          w;
        logic [2:0]  cmd;
        logic [13:0] addr;
        logic [31:0] wd, exp_rd;
        drive_reqs();
        e0 = pend[0] && (pcmd[0] != OP_NOP);
        e1 = pend[1] && (pcmd[1] != OP_NOP);
        if (!e0 && !e1) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("nop_no_gnt", {r1_gnt, r0_gnt}, 0);
            end
            pend[0] = 0; pend[1] = 0;
            drive_reqs();
            return;
        end
        w    = (e0 && e1) ? (last ? 0 : 1) : (e1 ? 1 : 0);
        last = (w == 1);
        cmd  = pcmd[w]; addr = paddr[w]; wd = pwd[w];
        wr   = (cmd >= 3'd5);

        c1_in = 3'($urandom_range(0, 7)); d1_in = DW'($urandom);
        tick();  // CMD1
        check("cmd1_gnt", {r1_gnt, r0_gnt}, (w == 1) ? 2 : 1);
        check("cmd1_done", {r1_done, r0_done}, 0);
        check("cmd1_c1", c1_out, cmd);
        check("cmd1_a1", a1_out, addr[13:4]);
        check("cmd1_oe", d1_oe, wr);
        if (wr) check("cmd1_d1", d1_out, wd[15:0]);
        pend[w] = 0;
        drive_reqs();

        c1_in = 3'($urandom_range(0, 7)); d1_in = DW'($urandom);
        tick();  // CMD2
        check("cmd2_gnt", {r1_gnt, r0_gnt}, 0);
        check("cmd2_c1", c1_out, cmd);
        check("cmd2_a1", a1_out, addr[3:0]);
        check("cmd2_oe", d1_oe, cmd == OP_WRITE32);
        if (cmd == OP_WRITE32) check("cmd2_d1", d1_out, wd[31:16]);

        tick();  // first WAIT cycle
        responded = 0; timed = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == delay) begin c1_in = 3'd7; d1_in = dlo; end
            else begin c1_in = 3'($urandom_range(0, 6)); d1_in = DW'($urandom); end
            check("wait_c1", c1_out, 0);
            check("wait_oe", d1_oe, 0);
            check("wait_a1", a1_out, 0);
            check("wait_done", {r1_done, r0_done, timeout_err}, 0);
            if (rst_mid && k == 1) begin
                #2 RESET = 1'b1;
                #1;
                check("rst_outs", {r1_gnt, r0_gnt, r1_done, r0_done, timeout_err, d1_oe, c1_out}, 0);
                check("rst_a1d1", {a1_out, d1_out}, 0);
                c1_in = 3'd7;
                tick();
                RESET = 1'b0;
                last  = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    check("rst_no_done", {r1_done, r0_done, r1_gnt, r0_gnt, timeout_err}, 0);
                    tick();
                end
                c1_in = 3'd0;
                return;
            end
            responded = (k == delay);
            timed     = !responded && (k == TO - 1);
            tick();
            if (responded || timed) break;
        end

        if (responded && cmd == OP_READ32) begin
            c1_in = 3'd7; d1_in = dhi;
            check("resp2_c1", c1_out, 0);
            check("resp2_done", {r1_done, r0_done}, 0);
            tick();
        end

        c1_in = 3'd0; d1_in = DW'($urandom);
        if (timed)                  exp_rd = 32'h0;
        else if (cmd == OP_READ8)   exp_rd = {24'h0, dlo[7:0]};
        else if (cmd == OP_READ16)  exp_rd = {16'h0, dlo};
        else if (cmd == OP_READ32)  exp_rd = {dhi, dlo};
        else                        exp_rd = 32'h0;
        check("done_pulse", {r1_done, r0_done}, (w == 1) ? 2 : 1);
        check("done_rdata", (w == 1) ? r1_rdata : r0_rdata, exp_rd);
        check("done_tmo", timeout_err, timed);
        check("done_gnt", {r1_gnt, r0_gnt}, 0);
        tick();  // back to IDLE
        check("idle_done", {r1_done, r0_done, timeout_err}, 0);
    endtask

    initial begin
        RESET = 1'b1;
        c1_in = 3'd0; d1_in = '0;
        for (int n = 0; n < 2; n++) begin pend[n] = 0; pcmd[n] = 0; paddr[n] = 0; pwd[n] = 0; end
        last = 1'b1;
        drive_reqs();
        tick(); tick();
        check("reset_ctl", {r1_gnt, r0_gnt, r1_done, r0_done, timeout_err, d1_oe, c1_out}, 0);
        check("reset_bus", {a1_out, d1_out}, 0);
        check("reset_rd", r0_rdata | r1_rdata, 0);
        RESET = 1'b0;
        tick();

        post(0, OP_READ8, 14'h2A5, 32'h0);
        run_txn(0, 16'h00C3, 16'h0, 0);
        post(1, OP_WRITE32, 14'h1F3, 32'hDEADBEEF);
        run_txn(2, 16'h5A5A, 16'h0, 0);
        post(0, OP_READ16, 14'h011, 32'h0);
        post(1, OP_READ16, 14'h022, 32'h0);
        run_txn(1, 16'hA001, 16'h0, 0);
        post(0, OP_READ16, 14'h033, 32'h0);
        run_txn(0, 16'hA002, 16'h0, 0);
        post(1, OP_READ16, 14'h044, 32'h0);
        run_txn(3, 16'hA003, 16'h0, 0);
        pend[0] = 0; pend[1] = 0;
        post(1, OP_READ32, 14'h3C7, 32'h0);
        run_txn(1, 16'h1122, 16'h3344, 0);
        post(0, OP_READ16, 14'h100, 32'h0);
        run_txn(99, 16'h0, 16'h0, 0);
        post(0, OP_READ8, 14'h101, 32'h0);
        run_txn(0, 16'h77EE, 16'h0, 0);

        for (int t = 0; t < 200; t++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 1) == 1)
                    post(n, 3'($urandom_range(0, 7)), 14'($urandom), $urandom);
            run_txn(int'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 0);
        end

        pend[0] = 0; pend[1] = 0;
        tick();
        post(0, OP_READ8, 14'h2B0, 32'h0);
        run_txn(5, 16'h0, 16'h0, 1);
        post(0, OP_READ16, 14'h055, 32'h0);
        post(1, OP_READ16, 14'h066, 32'h0);
        run_txn(0, 16'hBEE5, 16'h0, 0);
        run_txn(1, 16'hCAFE, 16'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
